lif_neuron_scheduler: RTL
=========================

// Module: lif_neuron_scheduler
// PURPOSE
//  Time-multiplexes one 8-bit leaky-integrate-fire update datapath across NUM_NEURONS virtual neurons.
//  Holds per-neuron membrane potential and refractory counter in internal register arrays.
//  On each timestep tick, walks neurons 0..NUM_NEURONS-1 at one neuron per cycle and fetches each neuron's input current.
//  Emits spike events (index-tagged) to the downstream spike router and a step-done pulse.
// PARAMETERS
//  NUM_NEURONS  8                     number of virtual neurons; must be >= 2
//  IDX_W        $clog2(NUM_NEURONS)   neuron index width (derived; do not override)
// PORTS
//  clk              in   1      single clock; all state updates on posedge
//  reset            in   1      asynchronous, active-high; clears all state
//  tick             in   1      timestep start strobe, one cycle
//  threshold        in   8      signed firing threshold, shared by all neurons
//  decay            in   8      signed leak magnitude, shared
//  refractory_period in  8      unsigned refractory length in timesteps, shared
//  cur_addr         out  IDX_W  neuron index whose input current is requested
//  cur_data         in   8      signed input current for cur_addr; combinational, same cycle
//  spike_valid      out  1      one-cycle pulse: neuron spike_idx fired
//  spike_idx        out  IDX_W  index of the firing neuron
//  busy             out  1      high from the cycle after tick accept until step_done
//  step_done        out  1      one-cycle pulse at end of sweep
//  tick_overrun     out  1      one-cycle pulse when tick arrives while busy
//  dbg_idx          in   IDX_W  debug readout select
//  dbg_potential    out  8      membrane potential of neuron dbg_idx (combinational)
// BEHAVIOUR
//  Reset values: all potentials 0, all refractory counters 0, state IDLE, idx 0, spike_valid 0, spike_idx 0, busy 0, step_done 0, tick_overrun 0.
//  FSM: IDLE --tick--> RUN (idx=0) --idx==NUM_NEURONS-1--> DONE --> IDLE.
//  RUN lasts exactly NUM_NEURONS cycles; DONE lasts 1 cycle with step_done=1. Tick to step_done latency is NUM_NEURONS+1 cycles.
//  cur_addr = idx in RUN; it is 0 otherwise.
//  Per-neuron update in RUN cycle i (V=pot[i], R=ref[i], I=cur_data):
//   - R>0: ref[i]<=R-1; V unchanged; no spike.
//   - R==0 and signed V >= signed threshold: pot[i]<=V-threshold (8-bit wrap), ref[i]<=refractory_period, spike.
//   - otherwise: S = sx10(V)+sx10(I)+(V[7] ? sx10(decay) : -sx10(decay)), computed at 10-bit signed.
//     pot[i] <= saturate S to [-128,127].
//  The fire check uses the pre-update V; the fire branch overrides integration in that cycle.
//  Spike output is registered: spike_valid/spike_idx assert the cycle after neuron i's RUN cycle.
//  The last neuron's spike therefore coincides with step_done.
//  tick in RUN or DONE: ignored, sweep continues unaffected, tick_overrun pulses next cycle.
//  tick in the same cycle as the DONE->IDLE transition: ignored with overrun.
//  threshold/decay/refractory_period are sampled live each RUN cycle; the source must hold them stable during a sweep.
//  Reset asserted mid-sweep: immediate return to IDLE with all arrays cleared; no step_done is issued.
// STRUCTURE
//  Shared package lif_pkg: LIF_W=8, LIF_SUM_W=10, LIF_MAX=8'sd127, LIF_MIN=-8'sd128, FSM state enum {S_IDLE,S_RUN,S_DONE}.
//  Sub-module lif_update_core: purely combinational single-neuron datapath.
//   Inputs: V, R, I, threshold, decay, refractory_period. Outputs: next V, next R, fire.
//  The scheduler owns the FSM, idx counter, arrays and output registers.
// TESTING
//  1 Reset, thr=20, decay=0, ref=0, cur_data=10 all neurons, tick
//    -> busy 1 for NUM_NEURONS+1 cycles, step_done once, all pots=10, no spikes.
//  2 Continue with 2 more ticks
//    -> tick2: pots=20, no spike; tick3: each neuron spikes in index order, spike_idx 0..7 on consecutive cycles, pots=0.
//  3 Saturation: cur_data=100, decay=0, thr=127
//    -> pot 100 then 127 (clamped), not 200; cur_data=-100 from 0 -> -100 then -128.
//  4 Leak sign: V=10, decay=3, I=0 -> 7; V=-10, decay=3, I=0 -> -7.
//  5 Refractory: ref=2 after a spike
//    -> next 2 ticks leave pot unchanged and emit no spike; the 3rd tick integrates.
//  6 tick during RUN -> tick_overrun pulse, sweep length unchanged.
//    reset pulse mid-sweep -> IDLE, dbg_potential=0 for all dbg_idx, no step_done.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared widths, saturation limits and FSM state encoding for the LIF neuron scheduler.
package lif_pkg;
  localparam int LIF_W     = 8;
  localparam int LIF_SUM_W = 10;
  localparam logic signed [LIF_W-1:0] LIF_MAX = 8'sd127;
  localparam logic signed [LIF_W-1:0] LIF_MIN = 8'sh80;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } lif_state_t;
endpackage

// File: rtl/lif_update_core.sv
// Combinational single-neuron leaky-integrate-fire update: refractory countdown,
// threshold fire with subtractive reset, or leak-toward-zero integration with saturation.
module lif_update_core
  import lif_pkg::*;
(
  input  logic [LIF_W-1:0] v,
  input  logic [LIF_W-1:0] r,
  input  logic [LIF_W-1:0] i,
  input  logic [LIF_W-1:0] threshold,
  input  logic [LIF_W-1:0] decay,
  input  logic [LIF_W-1:0] refractory_period,
  output logic [LIF_W-1:0] v_next,
  output logic [LIF_W-1:0] r_next,
  output logic             fire
);
  localparam logic signed [LIF_SUM_W-1:0] SUM_MAX = LIF_SUM_W'(LIF_MAX);
  localparam logic signed [LIF_SUM_W-1:0] SUM_MIN = LIF_SUM_W'(LIF_MIN);

  logic signed [LIF_SUM_W-1:0] v_x;
  logic signed [LIF_SUM_W-1:0] i_x;
  logic signed [LIF_SUM_W-1:0] d_x;
  logic signed [LIF_SUM_W-1:0] sum;

  assign v_x = {{(LIF_SUM_W-LIF_W){v[LIF_W-1]}}, v};
  assign i_x = {{(LIF_SUM_W-LIF_W){i[LIF_W-1]}}, i};
  assign d_x = {{(LIF_SUM_W-LIF_W){decay[LIF_W-1]}}, decay};

  always_comb begin
    fire   = 1'b0;
    v_next = v;
    r_next = r;
    // Leak always pulls the potential toward zero, whichever side it sits on.
    sum    = v_x + i_x + (v[LIF_W-1] ? d_x : -d_x);
    if (r != '0) begin
      r_next = r - 1'b1;
    end else if ($signed(v) >= $signed(threshold)) begin
      fire   = 1'b1;
      v_next = v - threshold;
      r_next = refractory_period;
    end else if (sum > SUM_MAX) begin
      v_next = LIF_MAX;
    end else if (sum < SUM_MIN) begin
      v_next = LIF_MIN;
    end else begin
      v_next = sum[LIF_W-1:0];
    end
  end
endmodule

// File: rtl/lif_neuron_scheduler.sv
// Sweeps one shared LIF datapath across NUM_NEURONS virtual neurons per timestep tick,
// holding per-neuron state in register arrays and emitting index-tagged spikes.
module lif_neuron_scheduler
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [LIF_W-1:0] threshold,
  input  logic [LIF_W-1:0] decay,
  input  logic [LIF_W-1:0] refractory_period,
  output logic [IDX_W-1:0] cur_addr,
  input  logic [LIF_W-1:0] cur_data,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  output logic             busy,
  output logic             step_done,
  output logic             tick_overrun,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [LIF_W-1:0] dbg_potential
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  lif_state_t       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [LIF_W-1:0] pot_reg [NUM_NEURONS];
  logic [LIF_W-1:0] ref_reg [NUM_NEURONS];

  logic [LIF_W-1:0] v_next;
  logic [LIF_W-1:0] r_next;
  logic             fire;

  assign cur_addr      = (state_reg == S_RUN) ? idx_reg : '0;
  assign dbg_potential = pot_reg[dbg_idx];

  lif_update_core u_core (
    .v                 (pot_reg[idx_reg]),
    .r                 (ref_reg[idx_reg]),
    .i                 (cur_data),
    .threshold         (threshold),
    .decay             (decay),
    .refractory_period (refractory_period),
    .v_next            (v_next),
    .r_next            (r_next),
    .fire              (fire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      spike_valid  <= 1'b0;
      spike_idx    <= '0;
      busy         <= 1'b0;
      step_done    <= 1'b0;
      tick_overrun <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        pot_reg[n] <= '0;
        ref_reg[n] <= '0;
      end
    end else begin
      spike_valid  <= 1'b0;
      step_done    <= 1'b0;
      tick_overrun <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (tick) begin
            state_reg <= S_RUN;
            idx_reg   <= '0;
            busy      <= 1'b1;
          end
        end
        S_RUN: begin
          pot_reg[idx_reg] <= v_next;
          ref_reg[idx_reg] <= r_next;
          spike_valid      <= fire;
          if (fire) spike_idx <= idx_reg;
          tick_overrun     <= tick;
          if (idx_reg == LAST_IDX) begin
            // step_done is raised on entry so it is high for the whole DONE cycle.
            state_reg <= S_DONE;
            idx_reg   <= '0;
            step_done <= 1'b1;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_DONE: begin
          state_reg    <= S_IDLE;
          busy         <= 1'b0;
          tick_overrun <= tick;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule
